// File: rtl/gray_counter_conv.sv
// Up/down counter kept in binary, presented as registered binary and Gray code.
// Supports Gray-coded synchronous load, wrap or saturate at the limits, terminal count.
module gray_counter_conv #(
   parameter int WIDTH     = 4,
   parameter int WRAP_MODE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_CNT = '1;

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;

   logic [WIDTH-1:0] w_step;
   logic             w_at_limit;
   logic [WIDTH-1:0] w_next_bin;
   logic [WIDTH-1:0] w_next_gray;
   logic             w_next_wrap;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Limit handling: at a limit either wrap (flagging it) or hold the state.
   function automatic logic [WIDTH:0] limit_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] nxt,
                                                 input logic             at_limit);
      if (at_limit && (WRAP_MODE == 0)) begin
         return {1'b0, cur};
      end
      return {at_limit, nxt};
   endfunction

   always_comb begin
      w_step      = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
      w_at_limit  = up ? (r_bin == MAX_CNT) : (r_bin == '0);
      w_next_bin  = r_bin;
      w_next_wrap = 1'b0;
      w_next_gray = r_gray;
      if (load) begin
         w_next_bin  = gray2bin(load_gray);
         w_next_gray = load_gray;
      end else if (en) begin
         {w_next_wrap, w_next_bin} = limit_step(r_bin, w_step, w_at_limit);
         w_next_gray = bin2gray(w_next_bin);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_next_bin;
         r_gray <= w_next_gray;
         r_wrap <= w_next_wrap;
      end
   end

   assign bin_out  = r_bin;
   assign gray_out = r_gray;
   assign wrap     = r_wrap;
   assign tc       = w_at_limit;

endmodule

// File: tb/tb_gray_counter_conv.sv
// Bench for gray_counter_conv: wrapping and saturating 4-bit instances plus a
// wrapping 8-bit instance, all driven from shared inputs and tracked by a model.
module tb_gray_counter_conv;

   logic       clk = 1'b0;
   logic       rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
   logic [3:0] lg4 = '0;
   logic [7:0] lg8 = '0;

   logic [3:0] g4w, b4w, g4s, b4s;
   logic [7:0] g8, b8;
   logic       tc4w, wr4w, tc4s, wr4s, tc8, wr8;

   int nerr = 0;
   int nchk = 0;

   int mb[3];
   bit mw[3];
   int W[3]  = '{4, 4, 8};
   bit WM[3] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   gray_counter_conv #(.WIDTH(4), .WRAP_MODE(1)) dut4w (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg4),
      .gray_out(g4w), .bin_out(b4w), .tc(tc4w), .wrap(wr4w));

   gray_counter_conv #(.WIDTH(4), .WRAP_MODE(0)) dut4s (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg4),
      .gray_out(g4s), .bin_out(b4s), .tc(tc4s), .wrap(wr4s));

   gray_counter_conv #(.WIDTH(8), .WRAP_MODE(1)) dut8 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg8),
      .gray_out(g8), .bin_out(b8), .tc(tc8), .wrap(wr8));

   // Reference: the binary value whose Gray code equals g, found by search.
   function automatic int model_g2b(int g, int w);
      for (int v = 0; v < (1 << w); v++) begin
         if ((v ^ (v >> 1)) == g) return v;
      end
      return -1;
   endfunction

   function automatic int model_gray(int b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         int mx;
         int lg;
         mx = (1 << W[k]) - 1;
         lg = (k == 2) ? int'(lg8) : int'(lg4);
         mw[k] = 1'b0;
         if (rst) begin
            mb[k] = 0;
         end else if (load) begin
            mb[k] = model_g2b(lg, W[k]);
         end else if (en) begin
            if (up) begin
               if (mb[k] < mx) mb[k] = mb[k] + 1;
               else if (WM[k]) begin mb[k] = 0; mw[k] = 1'b1; end
            end else begin
               if (mb[k] > 0) mb[k] = mb[k] - 1;
               else if (WM[k]) begin mb[k] = mx; mw[k] = 1'b1; end
            end
         end
      end
   endtask

   function automatic logic model_tc(int k);
      return up ? (mb[k] == (1 << W[k]) - 1) : (mb[k] == 0);
   endfunction

   task automatic check_all();
      check("bin4w",  32'(b4w),  32'(mb[0]));
      check("gray4w", 32'(g4w),  32'(model_gray(mb[0])));
      check("wrap4w", 32'(wr4w), 32'(mw[0]));
      check("tc4w",   32'(tc4w), 32'(model_tc(0)));
      check("bin4s",  32'(b4s),  32'(mb[1]));
      check("gray4s", 32'(g4s),  32'(model_gray(mb[1])));
      check("wrap4s", 32'(wr4s), 32'(mw[1]));
      check("tc4s",   32'(tc4s), 32'(model_tc(1)));
      check("bin8",   32'(b8),   32'(mb[2]));
      check("gray8",  32'(g8),   32'(model_gray(mb[2])));
      check("wrap8",  32'(wr8),  32'(mw[2]));
      check("tc8",    32'(tc8),  32'(model_tc(2)));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic drive(logic r, logic e, logic u, logic l, logic [3:0] g4, logic [7:0] g8v);
      rst = r; en = e; up = u; load = l; lg4 = g4; lg8 = g8v;
   endtask

   typedef struct {
      logic       rst, en, up, load;
      logic [3:0] lg;
      logic [3:0] eb;
      logic [3:0] eg;
      logic       ew;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic r, logic e, logic u, logic l, logic [3:0] g,
                               logic [3:0] eb, logic [3:0] eg, logic ew);
      vec_t v;
      v.rst = r; v.en = e; v.up = u; v.load = l; v.lg = g;
      v.eb = eb; v.eg = eg; v.ew = ew;
      tbl.push_back(v);
   endfunction

   initial begin
      int wraps;
      logic [3:0] pg;

      // reset then count up 1..5
      add(1, 0, 0, 0, 4'h0, 4'd0, 4'b0000, 0);
      add(1, 0, 0, 0, 4'h0, 4'd0, 4'b0000, 0);
      add(0, 1, 1, 0, 4'h0, 4'd1, 4'b0001, 0);
      add(0, 1, 1, 0, 4'h0, 4'd2, 4'b0011, 0);
      add(0, 1, 1, 0, 4'h0, 4'd3, 4'b0010, 0);
      add(0, 1, 1, 0, 4'h0, 4'd4, 4'b0110, 0);
      add(0, 1, 1, 0, 4'h0, 4'd5, 4'b0111, 0);
      // load sweep over the Gray-to-binary table
      add(0, 0, 0, 1, 4'b1101, 4'd9,  4'b1101, 0);
      add(0, 0, 0, 1, 4'b0000, 4'd0,  4'b0000, 0);
      add(0, 0, 0, 1, 4'b0001, 4'd1,  4'b0001, 0);
      add(0, 0, 0, 1, 4'b0011, 4'd2,  4'b0011, 0);
      add(0, 0, 0, 1, 4'b0010, 4'd3,  4'b0010, 0);
      add(0, 0, 0, 1, 4'b0110, 4'd4,  4'b0110, 0);
      add(0, 0, 0, 1, 4'b0111, 4'd5,  4'b0111, 0);
      add(0, 0, 0, 1, 4'b0101, 4'd6,  4'b0101, 0);
      add(0, 0, 0, 1, 4'b0100, 4'd7,  4'b0100, 0);
      add(0, 0, 0, 1, 4'b1100, 4'd8,  4'b1100, 0);
      add(0, 0, 0, 1, 4'b1111, 4'd10, 4'b1111, 0);
      add(0, 0, 0, 1, 4'b1110, 4'd11, 4'b1110, 0);
      add(0, 0, 0, 1, 4'b1010, 4'd12, 4'b1010, 0);
      add(0, 0, 0, 1, 4'b1011, 4'd13, 4'b1011, 0);
      add(0, 0, 0, 1, 4'b1001, 4'd14, 4'b1001, 0);
      add(0, 0, 0, 1, 4'b1000, 4'd15, 4'b1000, 0);
      // wrap up at 15, wrap down at 0, then hold clears the pulse
      add(0, 1, 1, 0, 4'h0, 4'd0,  4'b0000, 1);
      add(0, 1, 0, 0, 4'h0, 4'd15, 4'b1000, 1);
      add(0, 0, 0, 0, 4'h0, 4'd15, 4'b1000, 0);
      // load 7, then load+en: load wins; count to 6; reset with en
      add(0, 0, 0, 1, 4'b0100, 4'd7, 4'b0100, 0);
      add(0, 1, 1, 1, 4'b0011, 4'd2, 4'b0011, 0);
      add(0, 1, 1, 0, 4'h0, 4'd3, 4'b0010, 0);
      add(0, 1, 1, 0, 4'h0, 4'd4, 4'b0110, 0);
      add(0, 1, 1, 0, 4'h0, 4'd5, 4'b0111, 0);
      add(0, 1, 1, 0, 4'h0, 4'd6, 4'b0101, 0);
      add(1, 1, 1, 0, 4'h0, 4'd0, 4'b0000, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].lg, 8'h00);
         cyc();
         check($sformatf("tbl%0d_bin", i),  32'(b4w),  32'(tbl[i].eb));
         check($sformatf("tbl%0d_gray", i), 32'(g4w),  32'(tbl[i].eg));
         check($sformatf("tbl%0d_wrap", i), 32'(wr4w), 32'(tbl[i].ew));
      end

      // terminal count before the wrapping edge
      drive(0, 0, 1, 1, 4'b1000, 8'h80);
      cyc();
      drive(0, 1, 1, 0, 4'h0, 8'h00);
      #1;
      check("tc_before_wrap", 32'(tc4w), 32'd1);
      cyc();
      check("tc_after_wrap", 32'(tc4w), 32'd0);

      // saturating instance held at 15 while counting up
      drive(0, 0, 1, 1, 4'b1000, 8'hFF);
      cyc();
      drive(0, 1, 1, 0, 4'h0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("sat_hold_bin", 32'(b4s), 32'd15);
         check("sat_hold_wrap", 32'(wr4s), 32'd0);
         check("sat_hold_tc", 32'(tc4s), 32'd1);
      end
      drive(0, 1, 0, 0, 4'h0, 8'h00);
      cyc();
      check("sat_down_bin", 32'(b4s), 32'd14);
      check("sat_down_gray", 32'(g4s), 32'b1001);

      // 8-bit free run through one full period
      drive(1, 0, 0, 0, 4'h0, 8'h00);
      cyc();
      drive(0, 1, 1, 0, 4'h0, 8'h00);
      wraps = 0;
      pg = g4w;
      for (int i = 0; i < 256; i++) begin
         cyc();
         if (wr8) wraps++;
         check("inv8", 32'(g8), 32'(b8 ^ (b8 >> 1)));
         check("onebit4", 32'($countones(g4w ^ pg)), 32'd1);
         pg = g4w;
      end
      check("wraps8", 32'(wraps), 32'd1);
      check("bin8_end", 32'(b8), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
               4'($urandom), 8'($urandom));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/gray_counter_conv.md
Name: gray_counter_conv

Overview:
- Parametrised up/down Gray-code counter with built-in Gray-to-binary conversion; generalises the 4-bit combinational Gray-to-binary converter to N bits and adds state.
- Holds the count internally in binary and presents it as both registered Gray and registered binary outputs.
- Supports synchronous load of a Gray-coded value, wrap-around or saturating mode, and a terminal-count indication.
- Used for Gray-coded pointers and position counters, and as a self-checking source for converter labs.

Parameters:
- WIDTH, 4, counter width in bits (WIDTH >= 2).
- WRAP_MODE, 1, 1 = wrap at limits; 0 = saturate at limits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_gray  input  WIDTH  Gray-coded value loaded when load=1.
- gray_out  output  WIDTH  registered Gray code of the current count.
- bin_out  output  WIDTH  registered binary count.
- tc  output  1  combinational terminal count: 1 when bin_out == max and up=1, or bin_out == 0 and up=0.
- wrap  output  1  registered one-cycle pulse on wrap-around.

Behaviour:
- Only the one clock, clk, is used; reset is synchronous and active-high (rst sampled at the rising edge of clk).
- Reset: on a rising clk edge with rst=1, bin_out=0, gray_out=0 and wrap=0. rst overrides load and en. There is no asynchronous path.
- Priority at each edge is rst > load > en. With none asserted, the state holds and wrap=0.
- Load:
  - Convert load_gray to binary combinationally: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - Register the result into bin_out and register load_gray itself into gray_out, so the new value is visible the cycle after load.
  - wrap=0 on a load cycle. Any pending count is discarded.
- Count (en=1, load=0):
  - up=1: next = bin_out + 1. up=0: next = bin_out - 1. Arithmetic is modulo 2^WIDTH.
  - gray_out <= next ^ (next >> 1). gray_out and bin_out update in the same edge and are always consistent; there is no extra latency on either.
  - Exactly one bit of gray_out changes per count step.
- Limits, WRAP_MODE=1:
  - max + 1 -> 0, and 0 - 1 -> max.
  - wrap=1 for exactly the cycle following that edge, then 0 unless wrapping again.
- Limits, WRAP_MODE=0:
  - At max with up=1, or at 0 with up=0, the state holds; gray_out and bin_out are unchanged and wrap stays 0.
- tc is combinational from bin_out and up, and is valid in both modes.
- A direction change takes effect on the next enabled edge with no dead cycle.
- load and en asserted together: load wins and no count occurs.
- Reset mid-count or mid-load: the state returns to 0 at that edge and the wrap pulse is cleared.
- Invariant: gray_out == bin_out ^ (bin_out >> 1) at all times after the first reset. Outputs before the first reset are don't-care.

Test Plan (WIDTH=4 unless stated):
1. rst=1 for 2 cycles, then en=1, up=1 for 5 cycles -> bin_out = 1,2,3,4,5 and gray_out = 0001,0011,0010,0110,0111. wrap=0 throughout. Each step changes exactly one Gray bit.
2. load=1 with load_gray=1101 -> next cycle bin_out=1001 (9) and gray_out=1101. Sweep all 16 load_gray values -> bin_out matches the standard Gray-to-binary table (e.g. 1000 -> 1111, 0100 -> 0111).
3. WRAP_MODE=1, load gray 1000 (15), en=1, up=1 -> tc=1 before the edge; after the edge bin_out=0, gray_out=0000, wrap=1 for one cycle. Then up=0 from 0 -> bin_out=15, gray_out=1000, wrap=1.
4. WRAP_MODE=0, at 15 with up=1 for 3 cycles -> bin_out stays 15, wrap=0, tc=1. Then up=0 -> 14 (gray 1001).
5. Simultaneous load=1, en=1, load_gray=0011 from state 7 -> bin_out=2, no increment. Then assert rst while en=1 at count 6 -> next cycle bin_out=0, gray_out=0000, wrap=0.
6. WIDTH=8, WRAP_MODE=1: free-run up for 256 cycles -> the invariant holds every cycle and exactly one wrap pulse occurs (at 255 -> 0).
